// File: rtl/ttc_sync.sv
// TTC timing block: BXN/orbit counters with offset preset, L1A and sync-error
// counters, and a lock FSM that qualifies bx0 alignment over several orbits.
module ttc_sync #(
  parameter int MXBXN          = 12,
  parameter int LHC_CYCLE      = 3564,
  parameter int MXORB          = 16,
  parameter int MXCNT          = 16,
  parameter int LOCK_COUNT     = 4,
  parameter int HOLD_UNTIL_BX0 = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ttc_bx0_i,
  input  logic             ttc_resync_i,
  input  logic             ttc_l1a_i,
  input  logic             counter_reset_i,
  input  logic [MXBXN-1:0] bxn_offset_i,
  output logic [MXBXN-1:0] bxn_counter_o,
  output logic [MXORB-1:0] orbit_counter_o,
  output logic [MXCNT-1:0] l1a_counter_o,
  output logic [MXCNT-1:0] sync_err_cnt_o,
  output logic             bx0_local_o,
  output logic             sync_err_o,
  output logic             locked_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [MXBXN-1:0] BXN_MAX  = MXBXN'(LHC_CYCLE - 1);
  localparam logic [3:0]       LOCK_N   = 4'(LOCK_COUNT);
  localparam state_t           S_IDLE   = (HOLD_UNTIL_BX0 != 0) ? S_WAIT : S_ACQ;

  logic [MXBXN-1:0] offset_lim_q, bxn_q, bxn_d;
  logic [MXORB-1:0] orbit_q, orbit_d;
  logic [MXCNT-1:0] l1a_cnt_q, err_cnt_q;
  logic [3:0]       good_q, good_d;
  state_t           state_q, state_d;
  logic             bx0_local_q, sync_err_q, err_d;
  logic             bxn_sync, good_bx0, bad_bx0, missed_bx0, resync_bx0, preset;

  assign bxn_sync   = (bxn_q == offset_lim_q);
  assign good_bx0   = ttc_bx0_i && bxn_sync;
  assign bad_bx0    = ttc_bx0_i && !bxn_sync;
  assign missed_bx0 = bxn_sync && !ttc_bx0_i;
  assign resync_bx0 = ttc_resync_i && ttc_bx0_i;
  assign preset     = (ttc_resync_i || state_q == S_WAIT) && !ttc_bx0_i;

  // BXN next value; orbit only advances on a natural wrap, never on a load
  always_comb begin
    bxn_d   = bxn_q + 1'b1;
    orbit_d = orbit_q;
    if (resync_bx0)
      bxn_d = (offset_lim_q == BXN_MAX) ? '0 : offset_lim_q + 1'b1;
    else if (preset)
      bxn_d = offset_lim_q;
    else if (bxn_q == BXN_MAX) begin
      bxn_d   = '0;
      orbit_d = orbit_q + 1'b1;
    end
    if (ttc_resync_i)
      orbit_d = '0;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    if (resync_bx0) begin
      state_d = S_ACQ;
      good_d  = 4'd1;
    end else if (ttc_resync_i) begin
      state_d = S_IDLE;
      good_d  = '0;
    end else begin
      unique case (state_q)
        S_WAIT: if (ttc_bx0_i) begin
          state_d = S_ACQ;
          good_d  = 4'd1;
        end
        S_ACQ: if (good_bx0) begin
          good_d = good_q + 1'b1;
          if (good_q + 1'b1 >= LOCK_N)
            state_d = S_LOCKED;
        end else if (bad_bx0 || missed_bx0) begin
          good_d = '0;
          err_d  = 1'b1;
        end
        S_LOCKED: if (bad_bx0 || missed_bx0) begin
          state_d = S_ACQ;
          good_d  = '0;
          err_d   = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          good_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      offset_lim_q <= '0;
      bxn_q        <= '0;
      orbit_q      <= '0;
      l1a_cnt_q    <= '0;
      err_cnt_q    <= '0;
      good_q       <= '0;
      state_q      <= S_IDLE;
      bx0_local_q  <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      offset_lim_q <= (bxn_offset_i > BXN_MAX) ? BXN_MAX : bxn_offset_i;
      bxn_q        <= bxn_d;
      orbit_q      <= orbit_d;
      good_q       <= good_d;
      state_q      <= state_d;
      bx0_local_q  <= (bxn_q == '0);
      sync_err_q   <= err_d;
      if (counter_reset_i) begin
        l1a_cnt_q <= '0;
        err_cnt_q <= '0;
      end else begin
        if (ttc_l1a_i && l1a_cnt_q != '1)
          l1a_cnt_q <= l1a_cnt_q + 1'b1;
        if (sync_err_q && err_cnt_q != '1)
          err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign bxn_counter_o   = bxn_q;
  assign orbit_counter_o = orbit_q;
  assign l1a_counter_o   = l1a_cnt_q;
  assign sync_err_cnt_o  = err_cnt_q;
  assign bx0_local_o     = bx0_local_q;
  assign sync_err_o      = sync_err_q;
  assign locked_o        = (state_q == S_LOCKED);
  assign state_o         = state_q;

endmodule

// File: tb/tb_ttc_sync.sv
// Directed bench for ttc_sync: hold, lock, late bx0, clamp/wrap, resync+bx0,
// counter saturation/clear and mid-orbit reset with hand-computed expectations.
module tb_ttc_sync;

  logic        clock = 1'b0;
  logic        reset, ttc_bx0, ttc_resync, ttc_l1a, counter_reset;
  logic [11:0] bxn_offset, bxn_counter;
  logic [15:0] orbit_counter, l1a_counter, sync_err_cnt;
  logic        bx0_local, sync_err, locked;
  logic [1:0]  state;

  int nvec = 0;
  int nerr = 0;

  ttc_sync dut (
    .clock           (clock),
    .reset           (reset),
    .ttc_bx0_i       (ttc_bx0),
    .ttc_resync_i    (ttc_resync),
    .ttc_l1a_i       (ttc_l1a),
    .counter_reset_i (counter_reset),
    .bxn_offset_i    (bxn_offset),
    .bxn_counter_o   (bxn_counter),
    .orbit_counter_o (orbit_counter),
    .l1a_counter_o   (l1a_counter),
    .sync_err_cnt_o  (sync_err_cnt),
    .bx0_local_o     (bx0_local),
    .sync_err_o      (sync_err),
    .locked_o        (locked),
    .state_o         (state)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bxn_offset = 12'd160;
    step(2);
    nvec++; if (bxn_counter !== 12'd0) begin nerr++; $display("FAIL reset_bxn: got %0d expected 0", bxn_counter); end
    nvec++; if (state !== 2'd0) begin nerr++; $display("FAIL reset_state: got %0d expected 0", state); end
    nvec++; if ({locked, sync_err, bx0_local} !== 3'b000) begin nerr++; $display("FAIL reset_flags: got %b expected 000", {locked, sync_err, bx0_local}); end
    nvec++; if ({orbit_counter, l1a_counter, sync_err_cnt} !== 48'd0) begin nerr++; $display("FAIL reset_counters: got %h expected 0", {orbit_counter, l1a_counter, sync_err_cnt}); end
  endtask

  task automatic test_hold;
    reset = 1'b0;
    step(3);
    nvec++; if (bxn_counter !== 12'd160) begin nerr++; $display("FAIL hold_bxn: got %0d expected 160", bxn_counter); end
    nvec++; if (state !== 2'd0) begin nerr++; $display("FAIL hold_state: got %0d expected 0", state); end
    ttc_bx0 = 1'b1; step(1); ttc_bx0 = 1'b0;
    nvec++; if (bxn_counter !== 12'd161) begin nerr++; $display("FAIL hold_bx0_bxn: got %0d expected 161", bxn_counter); end
    nvec++; if (state !== 2'd1) begin nerr++; $display("FAIL hold_bx0_state: got %0d expected 1", state); end
    nvec++; if (sync_err !== 1'b0) begin nerr++; $display("FAIL hold_bx0_err: got %b expected 0", sync_err); end
  endtask

  // 3563 edges take the counter from 161 back round to 160, passing one wrap
  task automatic test_lock;
    for (int k = 1; k <= 3; k++) begin
      step(3563);
      nvec++; if (bxn_counter !== 12'd160) begin nerr++; $display("FAIL lock_bxn[%0d]: got %0d expected 160", k, bxn_counter); end
      nvec++; if (orbit_counter !== 16'(k)) begin nerr++; $display("FAIL lock_orbit[%0d]: got %0d expected %0d", k, orbit_counter, k); end
      ttc_bx0 = 1'b1; step(1); ttc_bx0 = 1'b0;
      nvec++; if (locked !== (k == 3)) begin nerr++; $display("FAIL lock_locked[%0d]: got %b expected %b", k, locked, (k == 3)); end
      nvec++; if (sync_err !== 1'b0) begin nerr++; $display("FAIL lock_err[%0d]: got %b expected 0", k, sync_err); end
    end
  endtask

  task automatic test_late_bx0;
    step(3563);
    nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL late_prelock: got %b expected 1", locked); end
    step(1);
    nvec++; if ({sync_err, locked} !== 2'b10) begin nerr++; $display("FAIL late_missed: got err/lock %b expected 10", {sync_err, locked}); end
    nvec++; if (state !== 2'd1) begin nerr++; $display("FAIL late_state: got %0d expected 1", state); end
    nvec++; if (bxn_counter !== 12'd161) begin nerr++; $display("FAIL late_bxn: got %0d expected 161", bxn_counter); end
    ttc_bx0 = 1'b1; step(1); ttc_bx0 = 1'b0;
    nvec++; if (sync_err !== 1'b1) begin nerr++; $display("FAIL late_bad_err: got %b expected 1", sync_err); end
    nvec++; if (sync_err_cnt !== 16'd1) begin nerr++; $display("FAIL late_cnt1: got %0d expected 1", sync_err_cnt); end
    step(1);
    nvec++; if (sync_err !== 1'b0) begin nerr++; $display("FAIL late_err_clear: got %b expected 0", sync_err); end
    nvec++; if (sync_err_cnt !== 16'd2) begin nerr++; $display("FAIL late_cnt2: got %0d expected 2", sync_err_cnt); end
  endtask

  task automatic test_clamp_wrap;
    bxn_offset = 12'd4000;
    step(1);
    ttc_resync = 1'b1; step(1); ttc_resync = 1'b0;
    nvec++; if (bxn_counter !== 12'd3563) begin nerr++; $display("FAIL clamp_bxn: got %0d expected 3563", bxn_counter); end
    nvec++; if (orbit_counter !== 16'd0) begin nerr++; $display("FAIL clamp_orbit: got %0d expected 0", orbit_counter); end
    nvec++; if (state !== 2'd0) begin nerr++; $display("FAIL clamp_state: got %0d expected 0", state); end
    ttc_bx0 = 1'b1; step(1); ttc_bx0 = 1'b0;
    nvec++; if (bxn_counter !== 12'd0) begin nerr++; $display("FAIL wrap_bxn0: got %0d expected 0", bxn_counter); end
    nvec++; if (orbit_counter !== 16'd1) begin nerr++; $display("FAIL wrap_orbit: got %0d expected 1", orbit_counter); end
    nvec++; if (bx0_local !== 1'b0) begin nerr++; $display("FAIL wrap_bx0l_early: got %b expected 0", bx0_local); end
    step(1);
    nvec++; if (bxn_counter !== 12'd1) begin nerr++; $display("FAIL wrap_bxn1: got %0d expected 1", bxn_counter); end
    nvec++; if (bx0_local !== 1'b1) begin nerr++; $display("FAIL wrap_bx0l: got %b expected 1", bx0_local); end
    step(1);
    nvec++; if (bx0_local !== 1'b0) begin nerr++; $display("FAIL wrap_bx0l_pulse: got %b expected 0", bx0_local); end
  endtask

  task automatic test_resync_bx0;
    ttc_resync = 1'b1; ttc_bx0 = 1'b1; step(1);
    ttc_resync = 1'b0; ttc_bx0 = 1'b0;
    nvec++; if (bxn_counter !== 12'd0) begin nerr++; $display("FAIL rsbx0_bxn: got %0d expected 0", bxn_counter); end
    nvec++; if (state !== 2'd1) begin nerr++; $display("FAIL rsbx0_state: got %0d expected 1", state); end
    nvec++; if (sync_err !== 1'b0) begin nerr++; $display("FAIL rsbx0_err: got %b expected 0", sync_err); end
    step(1);
    nvec++; if (sync_err !== 1'b0) begin nerr++; $display("FAIL rsbx0_err2: got %b expected 0", sync_err); end
    nvec++; if (sync_err_cnt !== 16'd2) begin nerr++; $display("FAIL rsbx0_cnt_kept: got %0d expected 2", sync_err_cnt); end
  endtask

  // resync held so BXN parks at 3563 and no sync errors accrue meanwhile
  task automatic test_l1a_sat;
    ttc_resync = 1'b1; ttc_l1a = 1'b1;
    step(65535);
    nvec++; if (l1a_counter !== 16'hFFFF) begin nerr++; $display("FAIL l1a_full: got %0d expected 65535", l1a_counter); end
    step(4465);
    ttc_l1a = 1'b0;
    nvec++; if (l1a_counter !== 16'hFFFF) begin nerr++; $display("FAIL l1a_sat: got %0d expected 65535", l1a_counter); end
    nvec++; if (bxn_counter !== 12'd3563) begin nerr++; $display("FAIL l1a_bxn_park: got %0d expected 3563", bxn_counter); end
  endtask

  task automatic test_counter_reset;
    ttc_resync = 1'b0; ttc_bx0 = 1'b1; step(1); ttc_bx0 = 1'b0;
    step(5);
    nvec++; if (bxn_counter !== 12'd5) begin nerr++; $display("FAIL crst_pre_bxn: got %0d expected 5", bxn_counter); end
    nvec++; if (sync_err_cnt !== 16'd2) begin nerr++; $display("FAIL crst_pre_err: got %0d expected 2", sync_err_cnt); end
    counter_reset = 1'b1; step(1); counter_reset = 1'b0;
    nvec++; if (l1a_counter !== 16'd0) begin nerr++; $display("FAIL crst_l1a: got %0d expected 0", l1a_counter); end
    nvec++; if (sync_err_cnt !== 16'd0) begin nerr++; $display("FAIL crst_err: got %0d expected 0", sync_err_cnt); end
    nvec++; if (bxn_counter !== 12'd6) begin nerr++; $display("FAIL crst_bxn: got %0d expected 6", bxn_counter); end
    nvec++; if (orbit_counter !== 16'd1) begin nerr++; $display("FAIL crst_orbit: got %0d expected 1", orbit_counter); end
    nvec++; if (state !== 2'd1) begin nerr++; $display("FAIL crst_state: got %0d expected 1", state); end
  endtask

  task automatic test_reset_mid;
    ttc_l1a = 1'b1; step(3);
    nvec++; if (l1a_counter !== 16'd3) begin nerr++; $display("FAIL mid_l1a_pre: got %0d expected 3", l1a_counter); end
    reset = 1'b1; ttc_bx0 = 1'b1; ttc_resync = 1'b1;
    step(1);
    reset = 1'b0; ttc_bx0 = 1'b0; ttc_resync = 1'b0; ttc_l1a = 1'b0;
    nvec++; if (bxn_counter !== 12'd0) begin nerr++; $display("FAIL mid_bxn: got %0d expected 0", bxn_counter); end
    nvec++; if ({orbit_counter, l1a_counter, sync_err_cnt} !== 48'd0) begin nerr++; $display("FAIL mid_counters: got %h expected 0", {orbit_counter, l1a_counter, sync_err_cnt}); end
    nvec++; if (state !== 2'd0) begin nerr++; $display("FAIL mid_state: got %0d expected 0", state); end
    nvec++; if ({locked, sync_err, bx0_local} !== 3'b000) begin nerr++; $display("FAIL mid_flags: got %b expected 000", {locked, sync_err, bx0_local}); end
  endtask

  initial begin
    reset = 1'b1; ttc_bx0 = 1'b0; ttc_resync = 1'b0; ttc_l1a = 1'b0;
    counter_reset = 1'b0; bxn_offset = 12'd0;
    test_reset();
    test_hold();
    test_lock();
    test_late_bx0();
    test_clamp_wrap();
    test_resync_bx0();
    test_l1a_sat();
    test_counter_reset();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ttc_sync.md
Name: ttc_sync

Overview:
- Next-generation TTC timing block. Provides a parametrised bunch-crossing counter with offset preset, an orbit counter, and L1A and sync-error counters.
- A lock state machine qualifies bx0 alignment over several consecutive orbits before declaring lock.
- Sits in the control path between the TTC decoder and the trigger/DAQ logic; bxn_counter and locked feed data tagging and status registers.

Parameters:
- MXBXN, 12, width of BXN counter and offset.
- LHC_CYCLE, 3564, orbit length in BX; max BXN = LHC_CYCLE-1.
- MXORB, 16, width of orbit counter.
- MXCNT, 16, width of L1A and sync-error counters.
- LOCK_COUNT, 4, consecutive good bx0s needed to reach LOCKED (1..15).
- HOLD_UNTIL_BX0, 1, 1 = hold BXN at offset after reset/resync until first bx0; 0 = free-run.

Ports:
- clock  in  1  system 40 MHz clock.
- reset  in  1  synchronous, active-high.
- ttc_bx0  in  1  bunch-crossing-zero strobe.
- ttc_resync  in  1  resync strobe.
- ttc_l1a  in  1  L1A strobe.
- counter_reset  in  1  clears L1A and sync-error counters only.
- bxn_offset  in  MXBXN  BXN value loaded at preset.
- bxn_counter  out  MXBXN  current BXN.
- orbit_counter  out  MXORB  orbits since reset/resync.
- l1a_counter  out  MXCNT  L1A count, saturating.
- sync_err_cnt  out  MXCNT  sync-error count, saturating.
- bx0_local  out  1  registered strobe, high the cycle after bxn_counter==0.
- sync_err  out  1  one-cycle pulse per sync error.
- locked  out  1  state==LOCKED.
- state  out  2  WAIT=0, ACQUIRE=1, LOCKED=2.

Behaviour:
- Reset values:
  - all counters 0; bx0_local 0, sync_err 0, locked 0.
  - state = WAIT if HOLD_UNTIL_BX0, else ACQUIRE; good-bx0 count 0.
- Offset clamp:
  - offset_lim is registered: = bxn_offset if < LHC_CYCLE, else LHC_CYCLE-1.
  - 1-cycle latency; reset value 0.
- sync point: bxn_sync = (bxn_counter == offset_lim).
- good bx0 = ttc_bx0 && bxn_sync; bad bx0 = ttc_bx0 && !bxn_sync; missed bx0 = bxn_sync && !ttc_bx0.
- BXN next-value priority:
  1. resync && bx0: load offset_lim+1, wrapping to 0 when offset_lim==LHC_CYCLE-1.
  2. preset, where preset = (resync || state==WAIT) && !bx0: load offset_lim.
  3. bxn_counter==LHC_CYCLE-1: load 0.
  4. otherwise increment.
- Orbit counter:
  - cleared on reset or resync.
  - otherwise +1 when BXN wraps LHC_CYCLE-1 -> 0 via rule 3; wraps modulo 2^MXORB.
- L1A counter: cleared on reset/counter_reset (priority over l1a); else +1 per ttc_l1a, saturating at all-ones.
- State machine (registered, priority top-down):
  - resync && bx0: -> ACQUIRE, good count 1; this bx0 is good by definition, no error.
  - resync: -> WAIT if HOLD_UNTIL_BX0, else ACQUIRE; good count 0.
  - WAIT: any bx0 -> ACQUIRE, good count 1, no error; no errors are ever flagged in WAIT.
  - ACQUIRE:
    - good bx0: count+1; on reaching LOCK_COUNT -> LOCKED.
    - bad or missed bx0: count 0, sync_err pulse.
  - LOCKED: bad or missed bx0 -> ACQUIRE, count 0, sync_err pulse.
- sync_err:
  - registered, asserted the cycle after the error condition.
  - sync_err_cnt +1 per pulse, saturating at all-ones; cleared by reset/counter_reset only, not by resync.
- locked deasserts the cycle after the error cycle, coincident with the sync_err pulse.
- Reset mid-orbit: all state returns to reset values next cycle regardless of other inputs.

Test Plan:
- HOLD: reset, offset=160, wait 3 cycles -> bxn_counter held at 160, state=WAIT. bx0 at cycle T -> bxn_counter=161 at T+1, state=ACQUIRE, sync_err stays 0.
- Lock: bx0 every 3564 cycles from the scenario above -> locked=1 the cycle after the 4th bx0 (3rd periodic); orbit_counter increments once per 3564 cycles.
- Late bx0 while LOCKED:
  - bx0 arrives one cycle late (counter 161) -> sync_err pulse after the missed cycle (at 160), locked=0.
  - a second pulse follows for the bad bx0 at 161; sync_err_cnt=2.
- Clamp/wrap: offset=4000 -> offset_lim=3563. Resync then bx0 -> counter sequence 3563, 0, 1, ...; orbit_counter 0 -> 1 at the wrap; bx0_local high one cycle after counter==0.
- Simultaneous resync+bx0 with offset=3563 -> bxn_counter=0 next cycle, state=ACQUIRE, no sync_err.
- Counters:
  - 70000 L1As with MXCNT=16 -> l1a_counter=65535 (saturated).
  - counter_reset pulse -> l1a_counter=0 and sync_err_cnt=0; bxn_counter, orbit_counter and state unchanged.
